// File: rtl/button_event_queue.sv
// Turns the nine resolved button lines into key events (press + auto-repeat)
// and queues them in a small first-word-fall-through FIFO behind valid/ready.
module button_event_queue #(
  parameter int unsigned DELAY_CYCLES = 50000000,
  parameter int unsigned RATE_CYCLES  = 10000000,
  parameter logic [8:0]  REPEAT_EN    = 9'h1E0,
  parameter int unsigned DEPTH        = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     button0_in,
  input  logic                     button1_in,
  input  logic                     button2_in,
  input  logic                     button3_in,
  input  logic                     button_enter_in,
  input  logic                     button_left_in,
  input  logic                     button_right_in,
  input  logic                     button_up_in,
  input  logic                     button_down_in,
  output logic [3:0]               event_code,
  output logic                     event_repeat,
  output logic                     event_valid,
  input  logic                     event_ready,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned EW = 5;
  localparam logic [31:0] DELAY_LAST = 32'(DELAY_CYCLES - 1);
  localparam logic [31:0] RATE_LAST  = 32'(RATE_CYCLES - 1);

  logic [8:0]    r_sample;
  logic [8:0]    r_prev;
  logic [31:0]   r_cnt;
  logic          r_rate_phase;
  logic [EW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [LW-1:0] r_level;
  logic          r_valid;
  logic          r_overflow;

  logic          w_cur_act;
  logic [3:0]    w_cur_code;
  logic          w_cur_rpt_en;
  logic          w_prev_act;
  logic [3:0]    w_prev_code;
  logic          w_press;
  logic          w_hold;
  logic          w_fire;
  logic          w_event;
  logic [EW-1:0] w_entry;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [LW-1:0] w_level_nxt;

  // Sample stage plus one-cycle history for edge/change detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sample <= '0;
      r_prev   <= '0;
    end else begin
      r_sample <= {button_down_in, button_up_in, button_right_in, button_left_in,
                   button_enter_in, button3_in, button2_in, button1_in, button0_in};
      r_prev   <= r_sample;
    end
  end

  // Priority encode: scanning downward leaves the lowest set index (button0 wins).
  always_comb begin
    w_cur_act    = 1'b0;
    w_cur_code   = '0;
    w_cur_rpt_en = 1'b0;
    w_prev_act   = 1'b0;
    w_prev_code  = '0;
    for (int i = 8; i >= 0; i--) begin
      if (r_sample[i]) begin
        w_cur_act    = 1'b1;
        w_cur_code   = 4'(i);
        w_cur_rpt_en = REPEAT_EN[i];
      end
      if (r_prev[i]) begin
        w_prev_act  = 1'b1;
        w_prev_code = 4'(i);
      end
    end
  end

  assign w_press = w_cur_act && (!w_prev_act || (w_cur_code != w_prev_code));
  assign w_hold  = w_cur_act && !w_press && w_cur_rpt_en;
  assign w_fire  = w_hold && (r_cnt == (r_rate_phase ? RATE_LAST : DELAY_LAST));

  // Repeat timer: first interval is DELAY, later ones RATE; any break restarts it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt        <= '0;
      r_rate_phase <= 1'b0;
    end else if (w_press || !w_hold) begin
      r_cnt        <= '0;
      r_rate_phase <= 1'b0;
    end else if (w_fire) begin
      r_cnt        <= '0;
      r_rate_phase <= 1'b1;
    end else begin
      r_cnt        <= r_cnt + 32'd1;
    end
  end

  assign w_event     = w_press || w_fire;
  assign w_entry     = {w_fire, w_cur_code};
  assign w_full      = (r_level == LW'(DEPTH));
  assign w_pop       = r_valid && event_ready;
  assign w_push      = w_event && (!w_full || w_pop);
  assign w_drop      = w_event && w_full && !w_pop;
  assign w_level_nxt = r_level + LW'(w_push) - LW'(w_pop);

  // Event FIFO; storage is cleared on reset so the head reads zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= w_entry;
        r_wptr        <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      r_level    <= w_level_nxt;
      r_valid    <= (w_level_nxt != '0);
      r_overflow <= w_drop;
    end
  end

  assign event_code   = r_mem[r_rptr][3:0];
  assign event_repeat = r_mem[r_rptr][4];
  assign event_valid  = r_valid;
  assign overflow     = r_overflow;
  assign fifo_level   = r_level;

endmodule

// File: tb/tb_button_event_queue.sv
// Scoreboard bench for button_event_queue: expected events are queued at stimulus
// time and matched (content and, where fixed, arrival cycle) as the consumer pops.
module tb_button_event_queue;

  logic       clk;
  logic       reset;
  logic [8:0] btn;
  logic [3:0] event_code;
  logic       event_repeat;
  logic       event_valid;
  logic       event_ready;
  logic       overflow;
  logic [2:0] fifo_level;

  typedef struct {
    logic [4:0] ent;
    int         cyc;
  } sb_t;

  sb_t sb[$];
  int  cyc;
  int  checks;
  int  errors;
  int  ovf_cnt;

  button_event_queue #(
    .DELAY_CYCLES(8),
    .RATE_CYCLES (4),
    .REPEAT_EN   (9'h1E0),
    .DEPTH       (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .button0_in     (btn[0]),
    .button1_in     (btn[1]),
    .button2_in     (btn[2]),
    .button3_in     (btn[3]),
    .button_enter_in(btn[4]),
    .button_left_in (btn[5]),
    .button_right_in(btn[6]),
    .button_up_in   (btn[7]),
    .button_down_in (btn[8]),
    .event_code     (event_code),
    .event_repeat   (event_repeat),
    .event_valid    (event_valid),
    .event_ready    (event_ready),
    .overflow       (overflow),
    .fifo_level     (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Consumer side: every handshake pops one scoreboard entry and is compared.
  always @(negedge clk) begin
    if (overflow) ovf_cnt++;
    if (!reset && event_valid && event_ready) begin
      sb_t e;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got rpt=%0d code=%0d at cyc %0d, required no event",
                 event_repeat, event_code, cyc);
      end else begin
        e = sb.pop_front();
        if (({event_repeat, event_code} !== e.ent) || (e.cyc >= 0 && cyc != e.cyc)) begin
          errors++;
          $display("FAIL pop: got rpt=%0d code=%0d at cyc %0d, required rpt=%0d code=%0d at cyc %0d",
                   event_repeat, event_code, cyc, e.ent[4], e.ent[3:0], e.cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 80 && sb.size() != 0; i++) tick();
    repeat (6) tick();
  endtask

  task automatic press_seq(input int first, input int last, input int push_last);
    for (int k = first; k <= last; k++) begin
      tick();
      btn = 9'(1 << k);
      if (k <= push_last) sb.push_back('{5'(k), -1});
      tick();
      btn = '0;
    end
    repeat (4) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    btn = '0;
    event_ready = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if ({event_valid, event_code, event_repeat, overflow, fifo_level} !== 10'd0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%0d code=%0d rpt=%0d ovf=%0d level=%0d, required all 0",
               event_valid, event_code, event_repeat, overflow, fifo_level);
    end
    reset = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if (event_valid !== 1'b0 || fifo_level !== 3'd0) begin
      errors++;
      $display("FAIL empty_ready: got valid=%0d level=%0d, required 0/0", event_valid, fifo_level);
    end
  endtask

  task automatic test_single_press();
    int c0;
    int o0;
    o0 = ovf_cnt;
    event_ready = 1'b1;
    tick();
    c0 = cyc;
    btn[2] = 1'b1;
    sb.push_back('{5'h02, c0 + 2});
    repeat (3) tick();
    btn = '0;
    wait_drain();
    checks++;
    if (sb.size() != 0 || ovf_cnt != o0) begin
      errors++;
      $display("FAIL single_press: got pending=%0d ovf=%0d, required 0/0", sb.size(), ovf_cnt - o0);
    end
  endtask

  task automatic test_repeat();
    int c0;
    event_ready = 1'b1;
    tick();
    c0 = cyc;
    btn[7] = 1'b1;
    sb.push_back('{5'h07, c0 + 2});
    for (int k = 1; k <= 4; k++) sb.push_back('{5'h17, c0 + 6 + 4 * k});
    repeat (22) tick();
    btn = '0;
    wait_drain();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL repeat_up: got pending=%0d, required 0", sb.size());
    end
    tick();
    c0 = cyc;
    btn[0] = 1'b1;
    sb.push_back('{5'h00, c0 + 2});
    repeat (20) tick();
    btn = '0;
    wait_drain();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL no_repeat_b0: got pending=%0d, required 0", sb.size());
    end
  endtask

  task automatic test_overflow();
    int o0;
    o0 = ovf_cnt;
    event_ready = 1'b0;
    press_seq(0, 4, 3);
    @(negedge clk);
    checks++;
    if (fifo_level !== 3'd4 || ovf_cnt - o0 != 1) begin
      errors++;
      $display("FAIL overflow_fill: got level=%0d ovf_pulses=%0d, required 4/1",
               fifo_level, ovf_cnt - o0);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({event_valid, event_repeat, event_code} !== 6'b10_0000) begin
        errors++;
        $display("FAIL stall_head: got valid=%0d rpt=%0d code=%0d, required 1/0/0",
                 event_valid, event_repeat, event_code);
      end
    end
    tick();
    event_ready = 1'b1;
    wait_drain();
    checks++;
    if (sb.size() != 0 || fifo_level !== 3'd0) begin
      errors++;
      $display("FAIL overflow_drain: got pending=%0d level=%0d, required 0/0", sb.size(), fifo_level);
    end
  endtask

  task automatic test_full_pop_push();
    int o0;
    event_ready = 1'b0;
    press_seq(0, 3, 3);
    o0 = ovf_cnt;
    btn[5] = 1'b1;
    tick();
    btn = '0;
    event_ready = 1'b1;
    tick();
    event_ready = 1'b0;
    sb.push_back('{5'h05, -1});
    @(negedge clk);
    checks++;
    if (fifo_level !== 3'd4 || overflow !== 1'b0 || ovf_cnt != o0) begin
      errors++;
      $display("FAIL full_pop_push: got level=%0d ovf=%0d pulses=%0d, required 4/0/0",
               fifo_level, overflow, ovf_cnt - o0);
    end
    tick();
    event_ready = 1'b1;
    wait_drain();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL full_drain: got pending=%0d, required 0", sb.size());
    end
  endtask

  task automatic test_back_to_back();
    int c0;
    event_ready = 1'b1;
    tick();
    c0 = cyc;
    for (int k = 0; k < 4; k++) begin
      btn = 9'(1 << k);
      sb.push_back('{5'(k), c0 + 2 + k});
      tick();
    end
    btn = '0;
    wait_drain();
    tick();
    c0 = cyc;
    btn = 9'h009;
    sb.push_back('{5'h00, c0 + 2});
    repeat (3) tick();
    btn = '0;
    wait_drain();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL back_to_back: got pending=%0d, required 0", sb.size());
    end
  endtask

  task automatic test_reset_mid();
    int r;
    event_ready = 1'b0;
    tick();
    btn[8] = 1'b1;
    repeat (6) tick();
    @(negedge clk);
    checks++;
    if (fifo_level !== 3'd1) begin
      errors++;
      $display("FAIL pre_reset_level: got %0d, required 1", fifo_level);
    end
    tick();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      @(negedge clk);
      checks++;
      if ({event_valid, event_code, event_repeat, overflow, fifo_level} !== 10'd0) begin
        errors++;
        $display("FAIL mid_reset: got valid=%0d code=%0d rpt=%0d ovf=%0d level=%0d, required all 0",
                 event_valid, event_code, event_repeat, overflow, fifo_level);
      end
    end
    reset = 1'b0;
    event_ready = 1'b1;
    r = cyc;
    sb.delete();
    sb.push_back('{5'h08, r + 2});
    sb.push_back('{5'h18, r + 10});
    repeat (11) tick();
    btn = '0;
    wait_drain();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL reset_repress: got pending=%0d, required 0", sb.size());
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    ovf_cnt = 0;
    reset = 1'b1;
    btn = '0;
    event_ready = 1'b1;
    test_reset();
    test_single_press();
    test_repeat();
    test_overflow();
    test_full_pop_push();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
